// File: rtl/somador_bcd_serial.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first.
// Subtraction uses nine's complement of B plus an initial carry of 1.
module somador_bcd_serial #(
  parameter int N_DIG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [4*N_DIG-1:0] A,
  input  logic [4*N_DIG-1:0] B,
  input  logic               Cin,
  output logic [4*N_DIG-1:0] S,
  output logic               Cout,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int W  = 4 * N_DIG;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_DIG - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   work_q, work_d;
  logic [W-1:0]   s_q, s_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           sub_q, sub_d;
  logic           c_q, c_d;
  logic           errp_q, errp_d;
  logic           cout_q, cout_d;
  logic           err_q, err_d;

  logic [3:0]     a_dig, b_dig, b_adj, dig;
  logic [4:0]     t;
  logic           c_next;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Current digit slice and its decimal-corrected sum.
  always_comb begin
    a_dig = a_q[{idx_q, 2'b00} +: 4];
    b_dig = b_q[{idx_q, 2'b00} +: 4];
    b_adj = sub_q ? (4'd9 - b_dig) : b_dig;
    t     = {1'b0, a_dig} + {1'b0, b_adj} + {4'b0000, c_q};
    if (t > 5'd9) begin
      dig    = t[3:0] + 4'd6;
      c_next = 1'b1;
    end else begin
      dig    = t[3:0];
      c_next = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    c_d     = c_q;
    idx_d   = idx_q;
    work_d  = work_q;
    errp_d  = errp_q;
    s_d     = s_q;
    cout_d  = cout_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          a_d     = A;
          b_d     = B;
          sub_d   = sub;
          c_d     = sub ? 1'b1 : Cin;
          idx_d   = '0;
          work_d  = '0;
          errp_d  = has_bad_digit(A) | has_bad_digit(B);
        end
      end
      CALC: begin
        work_d[{idx_q, 2'b00} +: 4] = dig;
        c_d   = c_next;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          // Last digit: publish the finished word, or zeros on a bad operand.
          state_d = DONE;
          idx_d   = '0;
          s_d     = errp_q ? '0 : work_d;
          cout_d  = errp_q ? 1'b0 : c_next;
          err_d   = errp_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: register updates use non-blocking assignments so all state advances together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      errp_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      errp_q  <= errp_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_somador_bcd_serial.sv
// Directed bench for somador_bcd_serial: a 4-digit and a 1-digit instance.
// Cycle 0 is the cycle in which start is sampled; done is expected in cycle N_DIG+1.
module tb_somador_bcd_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0, s4;
  logic        cout4, busy4, done4, err4;
  logic        start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0, s1;
  logic        cout1, busy1, done1, err1;

  int n_checks = 0;
  int n_fail   = 0;

  somador_bcd_serial #(.N_DIG(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .A(a4), .B(b4), .Cin(cin4),
    .S(s4), .Cout(cout4), .busy(busy4), .done(done4), .err(err4)
  );

  somador_bcd_serial #(.N_DIG(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .A(a1), .B(b1), .Cin(cin1),
    .S(s1), .Cout(cout1), .busy(busy1), .done(done1), .err(err1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: {Cout, S} for a 4-digit operation.
  function automatic logic [16:0] ref_model(input logic [15:0] a, b, input logic cin, sm);
    int ai, bi, r, rem;
    logic [15:0] s;
    ai = 0; bi = 0;
    for (int k = 3; k >= 0; k--) begin
      ai = ai * 10 + int'(a[4*k +: 4]);
      bi = bi * 10 + int'(b[4*k +: 4]);
    end
    r   = sm ? ai + (9999 - bi) + 1 : ai + bi + int'(cin);
    rem = r % 10000;
    s   = '0;
    for (int k = 0; k < 4; k++) begin
      s[4*k +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return {(r >= 10000), s};
  endfunction

  // Drives one operation from IDLE, follows it to DONE and one cycle past.
  // glitches counts cycles where busy/done/S/Cout misbehaved around the result.
  task automatic run_op(input logic [15:0] a, b, input logic cin, sm,
                        output logic [15:0] s_o, output logic c_o, e_o,
                        output int done_cyc, output int glitches);
    logic [15:0] s_hold;
    logic        c_hold;
    a4 = a; b4 = b; cin4 = cin; sub4 = sm; start4 = 1'b1;
    s_hold = s4; c_hold = cout4;
    done_cyc = -1; glitches = 0;
    s_o = 'x; c_o = 1'bx; e_o = 1'bx;
    step();
    start4 = 1'b0;
    for (int k = 1; k <= 12 && done_cyc < 0; k++) begin
      if (done4) begin
        done_cyc = k; s_o = s4; c_o = cout4; e_o = err4;
        if (!busy4) glitches++;
      end else begin
        if (!busy4 || s4 !== s_hold || cout4 !== c_hold) glitches++;
        step();
      end
    end
    step();
    if (busy4 || done4 || s4 !== s_o || cout4 !== c_o) glitches++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if ({s4, cout4, busy4, done4, err4} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset4: got S=%h C=%b busy=%b done=%b err=%b, want all 0", s4, cout4, busy4, done4, err4);
    end
    n_checks++;
    if ({s1, cout1, busy1, done1, err1} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset1: got S=%h C=%b busy=%b done=%b err=%b, want all 0", s1, cout1, busy1, done1, err1);
    end
  endtask

  // Runs one vector and compares result, latency and cycle behaviour to hand values.
  task automatic test_vector(input string name, input logic [15:0] a, b, input logic cin, sm,
                             input logic [15:0] exp_s, input logic exp_c, exp_e);
    logic [15:0] s; logic c, e; int dc, gl;
    run_op(a, b, cin, sm, s, c, e, dc, gl);
    n_checks++;
    if ({s, c, e} !== {exp_s, exp_c, exp_e}) begin
      n_fail++;
      $display("FAIL %s result: got S=%h C=%b err=%b, want S=%h C=%b err=%b", name, s, c, e, exp_s, exp_c, exp_e);
    end
    n_checks++;
    if (dc !== 5) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d, want 5", name, dc);
    end
    n_checks++;
    if (gl !== 0) begin
      n_fail++;
      $display("FAIL %s cycle_trace: got %0d bad cycles, want 0", name, gl);
    end
  endtask

  task automatic test_add_carry();
    test_vector("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    test_vector("ovf_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_vector("ovf_9999_9999_c", 16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0);
  endtask

  task automatic test_subtract();
    test_vector("sub_0100_0007", 16'h0100, 16'h0007, 1'b0, 1'b1, 16'h0093, 1'b1, 1'b0);
    test_vector("sub_0007_0100", 16'h0007, 16'h0100, 1'b0, 1'b1, 16'h9907, 1'b0, 1'b0);
    test_vector("sub_5555_5555", 16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    test_vector("sub_ignores_cin", 16'h0100, 16'h0007, 1'b1, 1'b1, 16'h0093, 1'b1, 1'b0);
  endtask

  task automatic test_invalid();
    test_vector("bad_digit", 16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    test_vector("err_clears", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
  endtask

  task automatic test_model_sweep();
    logic [33:0] vecs [5] = '{
      {16'h4821, 16'h3179, 1'b1, 1'b0},
      {16'h0500, 16'h0499, 1'b0, 1'b1},
      {16'h0000, 16'h0001, 1'b0, 1'b1},
      {16'h9090, 16'h0909, 1'b0, 1'b0},
      {16'h0865, 16'h9135, 1'b1, 1'b0}
    };
    logic [16:0] exp;
    logic [15:0] s; logic c, e; int dc, gl;
    for (int i = 0; i < 5; i++) begin
      exp = ref_model(vecs[i][33:18], vecs[i][17:2], vecs[i][1], vecs[i][0]);
      run_op(vecs[i][33:18], vecs[i][17:2], vecs[i][1], vecs[i][0], s, c, e, dc, gl);
      n_checks++;
      if ({c, s, e, dc, gl} !== {exp, 1'b0, 5, 0}) begin
        n_fail++;
        $display("FAIL model_%0d: got C=%b S=%h err=%b done=%0d bad=%0d, want C=%b S=%h err=0 done=5 bad=0",
                 i, c, s, e, dc, gl, exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_hazards();
    int dc;
    int stray;
    logic [15:0] s; logic c, e; int gl;
    // start pulse and operand changes while CALC is running
    a4 = 16'h2468; b4 = 16'h1357; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    a4 = 16'h9999; b4 = 16'h8888; sub4 = 1'b1; cin4 = 1'b1; start4 = 1'b1;
    step();
    start4 = 1'b0;
    dc = -1;
    for (int k = 3; k <= 12 && dc < 0; k++) begin
      if (done4) dc = k;
      else step();
    end
    n_checks++;
    if ({s4, cout4, err4} !== {16'h3825, 1'b0, 1'b0} || dc !== 5) begin
      n_fail++;
      $display("FAIL hazard_latched: got S=%h C=%b err=%b done=%0d, want S=3825 C=0 err=0 done=5", s4, cout4, err4, dc);
    end
    step(); step();
    n_checks++;
    if (busy4 !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_no_queue: got busy=%b, want 0", busy4);
    end
    // reset in the second CALC cycle
    a4 = 16'h1111; b4 = 16'h2222; start4 = 1'b1; sub4 = 1'b0; cin4 = 1'b0;
    step();
    start4 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({s4, cout4, busy4, done4, err4} !== 20'h0) begin
      n_fail++;
      $display("FAIL hazard_reset: got S=%h C=%b busy=%b done=%b err=%b, want all 0", s4, cout4, busy4, done4, err4);
    end
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      if (done4 || busy4) stray++;
      step();
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL hazard_no_done: got %0d active cycles after reset, want 0", stray);
    end
    run_op(16'h0042, 16'h0058, 1'b0, 1'b0, s, c, e, dc, gl);
    n_checks++;
    if ({s, c, e, dc, gl} !== {16'h0100, 1'b0, 1'b0, 5, 0}) begin
      n_fail++;
      $display("FAIL hazard_recover: got S=%h C=%b err=%b done=%0d bad=%0d, want S=0100 C=0 err=0 done=5 bad=0",
               s, c, e, dc, gl);
    end
  endtask

  task automatic test_ndig1();
    logic [5:0] vecs [2] = '{ {4'h7, 1'b1, 1'b0}, {4'h2, 1'b0, 1'b0} };
    logic [3:0] bv [2] = '{4'h6, 4'h3};
    logic [4:0] exp [2] = '{ {4'h3, 1'b1}, {4'h5, 1'b0} };
    int dc;
    for (int i = 0; i < 2; i++) begin
      a1 = vecs[i][5:2]; b1 = bv[i]; cin1 = 1'b0; sub1 = 1'b0; start1 = 1'b1;
      step();
      start1 = 1'b0;
      dc = -1;
      for (int k = 1; k <= 8 && dc < 0; k++) begin
        if (done1) dc = k;
        else step();
      end
      n_checks++;
      if ({s1, cout1, err1} !== {exp[i], 1'b0} || dc !== 2) begin
        n_fail++;
        $display("FAIL ndig1_%0d: got S=%h C=%b err=%b done=%0d, want S=%h C=%b err=0 done=2",
                 i, s1, cout1, err1, dc, exp[i][4:1], exp[i][0]);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_overflow();
    test_subtract();
    test_invalid();
    test_model_sweep();
    test_hazards();
    test_ndig1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/somador_bcd_serial.md
SOMADOR_BCD_SERIAL -- requirements
Module: somador_bcd_serial

Interface
REQ-001 The block SHALL have one parameter: N_DIG, default 4, number of BCD digits per operand; legal range 1..16.
REQ-002 The ports SHALL be exactly as follows:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request to start an operation.
- sub  input  1  mode select: 0 = A+B+Cin, 1 = A-B.
- A  input  4*N_DIG  operand A, N_DIG packed BCD digits, digit 0 in bits [3:0].
- B  input  4*N_DIG  operand B, same packing as A.
- Cin  input  1  decimal carry-in; add mode only.
- S  output  4*N_DIG  registered BCD result.
- Cout  output  1  registered decimal carry-out, or no-borrow flag in subtract mode.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle result-valid pulse.
- err  output  1  high with done when any latched operand digit was greater than 9.

Function
REQ-003 The FSM SHALL have three states, IDLE, CALC and DONE, with these transitions:
- IDLE to CALC on start=1.
- CALC to DONE on the edge that processes digit N_DIG-1.
- DONE to IDLE unconditionally on the next edge.
REQ-004 On the accepting edge (IDLE and start=1), the block SHALL latch A, B, Cin and sub into internal registers and clear the digit index to 0.
- Later changes on A, B, Cin or sub SHALL NOT affect the running operation.
REQ-005 start SHALL be ignored in the CALC and DONE states; no queuing, no restart.
REQ-006 In CALC, the block SHALL process one digit per clock, least-significant digit first.
- Index i advances 0..N_DIG-1.
- The result goes into an internal working register.
REQ-007 The per-digit operation SHALL be as follows:
- b' = B_i in add mode, or 9-B_i in subtract mode.
- t = A_i + b' + c, computed 5 bits wide.
- If t > 9: digit = (t+6) mod 16 and c = 1; otherwise digit = t and c = 0.
REQ-008 The initial carry c SHALL be Cin in add mode; in subtract mode it SHALL be 1 and Cin SHALL be ignored.
REQ-009 In subtract mode, the block SHALL produce the following results:
- Cout = 1 means A >= B, and S = A-B.
- Cout = 0 means A < B, and S is the 10's complement of B-A.
REQ-010 The output latency SHALL be as follows:
- On the edge that enters DONE, S, Cout and err SHALL be loaded.
- S and Cout SHALL be held unchanged until the next load; intermediate digits are never visible on S.
REQ-011 done SHALL be high exactly while in DONE: one cycle, N_DIG+1 cycles after the accepting edge.
REQ-012 busy SHALL be high in CALC and DONE and low in IDLE.
- busy SHALL rise on the accepting edge and fall on the DONE-to-IDLE edge.
REQ-013 The block SHALL support back-to-back operation: start held high SHALL be accepted again on the first IDLE cycle, i.e. one idle cycle between operations.
REQ-014 err SHALL be computed from the latched A and B, all digits, at accept time.
- If err = 1, the DONE load SHALL set S = 0 and Cout = 0 instead of the computed result.
- err SHALL be held like S until the next load.
REQ-015 For N_DIG = 1, CALC SHALL last exactly one cycle; behaviour SHALL otherwise be identical.

Reset
REQ-016 When rst = 1 at a rising edge, regardless of state or start, the block SHALL:
- set state = IDLE, S = 0, Cout = 0, busy = 0, done = 0, err = 0;
- clear the digit index and the working registers.
REQ-017 A reset during CALC or DONE SHALL abort the operation with no done pulse; rst SHALL take priority over start.

Verification
REQ-018 The bench SHALL run at N_DIG = 4 unless stated, checking outputs on every cycle against a decimal reference model.
REQ-019 Add with carry chain: A=1234, B=5678, Cin=0, sub=0 -> S=6912, Cout=0.
- busy rises on the accepting edge.
- done is high exactly 5 cycles after the accepting edge.
REQ-020 Full overflow: A=9999, B=0001, Cin=0 -> S=0000, Cout=1. With A=9999, B=9999, Cin=1 -> S=9999, Cout=1.
REQ-021 Subtract:
- 0100-0007 -> S=0093, Cout=1.
- 0007-0100 -> S=9907, Cout=0.
- 5555-5555 -> S=0000, Cout=1.
REQ-022 Invalid digit: A=12A4 (hex digit A), B=0001 -> err=1, S=0000, Cout=0 with done.
- The next valid operation SHALL clear err.
REQ-023 Control hazards:
- start pulsed during CALC -> ignored, result unchanged.
- Operands changed during CALC -> result reflects the latched values.
- rst asserted in the 2nd CALC cycle -> all outputs 0 next cycle, no done; a new start afterwards completes normally.
REQ-024 N_DIG = 1 instance: A=7, B=6 -> S=3, Cout=1, done 2 cycles after the accepting edge. A=2, B=3 -> S=5, Cout=0.
